// File: rtl/data_mem_interface.sv
// data_mem_interface: load/store stage between control_unit and a word-wide data memory.
// Optional macro DMEM_TIMEOUT_EN aborts a stalled bus access with err after TIMEOUT_CYCLES waits.
module data_mem_interface #(
    parameter int ADDR_W         = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rd_en,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       mem_write,
    input  logic [1:0]        size,
    input  logic              ld_unsigned,
    output logic [31:0]       mem_read,
    output logic              done,
    output logic              err,
    output logic              busy,
    output logic              bus_req,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [3:0]        bus_be,
    output logic [31:0]       bus_wdata,
    input  logic              bus_ready,
    input  logic [31:0]       bus_rdata
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t            state, state_nxt;
    logic [1:0]        lo_q, lo_nxt;
    logic [1:0]        size_q, size_nxt;
    logic              uns_q, uns_nxt;
    logic              we_q, we_nxt;
    logic [31:0]       mem_read_nxt;
    logic              done_nxt, err_nxt, busy_nxt;
    logic              bus_req_nxt, bus_we_nxt;
    logic [ADDR_W-1:0] bus_addr_nxt;
    logic [3:0]        bus_be_nxt;
    logic [31:0]       bus_wdata_nxt;
    logic              illegal;

`ifdef DMEM_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] wait_cnt, wait_cnt_nxt;
`endif

    function automatic logic [3:0] lane_be(input logic [1:0] sz, input logic [1:0] lo);
        case (sz)
            2'b00:   lane_be = 4'b0001 << lo;
            2'b01:   lane_be = lo[1] ? 4'b1100 : 4'b0011;
            default: lane_be = 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] lane_wdata(input logic [1:0] sz, input logic [31:0] d);
        case (sz)
            2'b00:   lane_wdata = {4{d[7:0]}};
            2'b01:   lane_wdata = {2{d[15:0]}};
            default: lane_wdata = d;
        endcase
    endfunction

    function automatic logic [31:0] load_extend(input logic [31:0] rdata, input logic [1:0] sz,
                                                input logic [1:0] lo, input logic uns);
        logic [7:0]  b;
        logic [15:0] h;
        b = rdata[{lo, 3'b000} +: 8];
        h = rdata[{lo[1], 4'b0000} +: 16];
        case (sz)
            2'b00:   load_extend = {{24{~uns & b[7]}}, b};
            2'b01:   load_extend = {{16{~uns & h[15]}}, h};
            default: load_extend = rdata;
        endcase
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            lo_q      <= 2'b00;
            size_q    <= 2'b00;
            uns_q     <= 1'b0;
            we_q      <= 1'b0;
            mem_read  <= 32'd0;
            done      <= 1'b0;
            err       <= 1'b0;
            busy      <= 1'b0;
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            bus_addr  <= '0;
            bus_be    <= 4'd0;
            bus_wdata <= 32'd0;
`ifdef DMEM_TIMEOUT_EN
            wait_cnt  <= '0;
`endif
        end else begin
            state     <= state_nxt;
            lo_q      <= lo_nxt;
            size_q    <= size_nxt;
            uns_q     <= uns_nxt;
            we_q      <= we_nxt;
            mem_read  <= mem_read_nxt;
            done      <= done_nxt;
            err       <= err_nxt;
            busy      <= busy_nxt;
            bus_req   <= bus_req_nxt;
            bus_we    <= bus_we_nxt;
            bus_addr  <= bus_addr_nxt;
            bus_be    <= bus_be_nxt;
            bus_wdata <= bus_wdata_nxt;
`ifdef DMEM_TIMEOUT_EN
            wait_cnt  <= wait_cnt_nxt;
`endif
        end
    end

    assign illegal = (rd_en & wr_en) || (size == 2'b11) ||
                     (size == 2'b01 && addr[0]) || (size == 2'b10 && addr[1:0] != 2'b00);

    always_comb begin
        state_nxt     = state;
        lo_nxt        = lo_q;
        size_nxt      = size_q;
        uns_nxt       = uns_q;
        we_nxt        = we_q;
        mem_read_nxt  = mem_read;
        done_nxt      = 1'b0;
        err_nxt       = 1'b0;
        busy_nxt      = busy;
        bus_req_nxt   = bus_req;
        bus_we_nxt    = bus_we;
        bus_addr_nxt  = bus_addr;
        bus_be_nxt    = bus_be;
        bus_wdata_nxt = bus_wdata;
`ifdef DMEM_TIMEOUT_EN
        wait_cnt_nxt  = wait_cnt;
`endif
        case (state)
            IDLE: begin
                if (rd_en | wr_en) begin
                    busy_nxt = 1'b1;
                    lo_nxt   = addr[1:0];
                    size_nxt = size;
                    uns_nxt  = ld_unsigned;
                    we_nxt   = wr_en;
                    if (illegal) begin
                        err_nxt   = 1'b1;
                        state_nxt = RESP;
                    end else begin
                        // Bus outputs are launched from the capture edge so bus_req appears one cycle later.
                        state_nxt     = ACCESS;
                        bus_req_nxt   = 1'b1;
                        bus_we_nxt    = wr_en;
                        bus_addr_nxt  = {addr[ADDR_W-1:2], 2'b00};
                        bus_be_nxt    = lane_be(size, addr[1:0]);
                        bus_wdata_nxt = wr_en ? lane_wdata(size, mem_write) : 32'd0;
`ifdef DMEM_TIMEOUT_EN
                        wait_cnt_nxt  = '0;
`endif
                    end
                end
            end
            ACCESS: begin
                if (bus_ready) begin
                    if (!we_q) mem_read_nxt = load_extend(bus_rdata, size_q, lo_q, uns_q);
                    done_nxt      = 1'b1;
                    state_nxt     = RESP;
                    bus_req_nxt   = 1'b0;
                    bus_we_nxt    = 1'b0;
                    bus_be_nxt    = 4'd0;
                    bus_wdata_nxt = 32'd0;
                end
`ifdef DMEM_TIMEOUT_EN
                else if (wait_cnt == CNT_W'(TIMEOUT_CYCLES)) begin
                    err_nxt       = 1'b1;
                    state_nxt     = RESP;
                    bus_req_nxt   = 1'b0;
                    bus_we_nxt    = 1'b0;
                    bus_be_nxt    = 4'd0;
                    bus_wdata_nxt = 32'd0;
                end else begin
                    wait_cnt_nxt = wait_cnt + CNT_W'(1);
                end
`endif
            end
            RESP: begin
                busy_nxt  = 1'b0;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_data_mem_interface.sv
// Randomized self-checking bench for data_mem_interface against a lane/extension reference model.
// Build with DMEM_TIMEOUT_EN defined to also exercise the bus timeout path.
module tb_data_mem_interface;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        rd_en = 1'b0, wr_en = 1'b0, ld_unsigned = 1'b0, bus_ready = 1'b0;
    logic [31:0] addr = 32'd0, mem_write = 32'd0, bus_rdata = 32'd0;
    logic [1:0]  size = 2'd0;
    logic [31:0] mem_read, bus_addr, bus_wdata;
    logic        done, err, busy, bus_req, bus_we;
    logic [3:0]  bus_be;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_rd = 32'd0;

    data_mem_interface #(.ADDR_W(32), .TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .rst(rst), .rd_en(rd_en), .wr_en(wr_en), .addr(addr),
        .mem_write(mem_write), .size(size), .ld_unsigned(ld_unsigned),
        .mem_read(mem_read), .done(done), .err(err), .busy(busy),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
        .bus_wdata(bus_wdata), .bus_ready(bus_ready), .bus_rdata(bus_rdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit m_legal(input bit rd, input bit wr, input int sz, input int a);
        if (rd && wr) return 0;
        if (sz == 3) return 0;
        if (sz == 1 && (a % 2) != 0) return 0;
        if (sz == 2 && a != 0) return 0;
        return 1;
    endfunction

    function automatic logic [3:0] m_be(input int sz, input int a);
        if (sz == 0) return 4'(1 << a);
        if (sz == 1) return 4'(3 << a);
        return 4'hF;
    endfunction

    function automatic logic [31:0] m_wdata(input int sz, input logic [31:0] d);
        if (sz == 0) return (d & 32'hFF) * 32'h0101_0101;
        if (sz == 1) return (d & 32'hFFFF) * 32'h0001_0001;
        return d;
    endfunction

    function automatic logic [31:0] m_load(input int sz, input int a, input bit uns, input logic [31:0] rdata);
        logic [31:0] v;
        v = rdata >> (8 * a);
        if (sz == 0) begin
            v = v & 32'hFF;
            if (!uns && v >= 32'h80) v = v | 32'hFFFF_FF00;
        end else if (sz == 1) begin
            v = v & 32'hFFFF;
            if (!uns && v >= 32'h8000) v = v | 32'hFFFF_0000;
        end else begin
            v = rdata;
        end
        return v;
    endfunction

    task automatic txn(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] wd,
                       input int sz, input bit uns, input int waits, input logic [31:0] rdata);
        int  lo;
        bit  ok;
        lo = int'(a[1:0]);
        ok = m_legal(rd, wr, sz, lo);
        @(negedge clk);
        rd_en = rd; wr_en = wr; addr = a; mem_write = wd; size = 2'(sz); ld_unsigned = uns;
        bus_rdata = $urandom;
        @(posedge clk);
        #1;
        rd_en = 1'b0; wr_en = 1'b0;
        @(negedge clk);
        check("busy_after_capture", 32'(busy), 32'd1);
        if (!ok) begin
            check("illegal_err", 32'(err), 32'd1);
            check("illegal_no_req", 32'(bus_req), 32'd0);
            check("illegal_no_done", 32'(done), 32'd0);
            @(negedge clk);
            check("illegal_err_pulse", 32'(err), 32'd0);
            check("illegal_busy_clear", 32'(busy), 32'd0);
            check("illegal_no_req2", 32'(bus_req), 32'd0);
            check("illegal_rd_kept", mem_read, exp_rd);
        end else begin
            for (int k = 1; k <= waits + 1; k++) begin
                if (k > 1) @(negedge clk);
                check("req_high", 32'(bus_req), 32'd1);
                check("bus_we", 32'(bus_we), 32'(wr));
                check("bus_addr", bus_addr, a & 32'hFFFF_FFFC);
                check("bus_be", 32'(bus_be), 32'(m_be(sz, lo)));
                check("bus_wdata", bus_wdata, wr ? m_wdata(sz, wd) : 32'd0);
                check("no_early_done", 32'(done), 32'd0);
                bus_ready = (k == waits + 1);
                if (k <= waits) begin
                    // Requests while busy must be ignored.
                    rd_en = 1'($urandom); wr_en = 1'($urandom);
                    addr = $urandom; size = 2'($urandom);
                    bus_rdata = $urandom;
                end else begin
                    rd_en = 1'b0; wr_en = 1'b0;
                    bus_rdata = rdata;
                end
            end
            @(negedge clk);
            bus_ready = 1'b0;
            if (rd) exp_rd = m_load(sz, lo, uns, rdata);
            check("done_pulse", 32'(done), 32'd1);
            check("req_dropped", 32'(bus_req), 32'd0);
            check("be_idle", 32'(bus_be), 32'd0);
            check("wdata_idle", bus_wdata, 32'd0);
            check("we_idle", 32'(bus_we), 32'd0);
            check("busy_in_resp", 32'(busy), 32'd1);
            check("mem_read", mem_read, exp_rd);
            @(negedge clk);
            check("done_one_cycle", 32'(done), 32'd0);
            check("busy_clear", 32'(busy), 32'd0);
        end
    endtask

    initial begin
        #1;
        check("rst_mem_read", mem_read, 32'd0);
        check("rst_flags", {27'd0, done, err, busy, bus_req, bus_we}, 32'd0);
        check("rst_bus", {bus_addr | bus_wdata}, 32'd0);
        check("rst_be", 32'(bus_be), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;

        // Directed cases from the test plan.
        txn(0, 1, 32'h1003, 32'h0000_00A5, 0, 0, 0, 32'd0);
        txn(1, 0, 32'h2001, 32'd0, 0, 0, 0, 32'h1234_80FF);
        check("lb_signed", mem_read, 32'hFFFF_FF80);
        txn(1, 0, 32'h2001, 32'd0, 0, 1, 0, 32'h1234_80FF);
        check("lbu", mem_read, 32'h0000_0080);
        txn(1, 0, 32'h2002, 32'd0, 1, 0, 3, 32'h8001_0000);
        check("lh_signed", mem_read, 32'hFFFF_8001);
        txn(0, 1, 32'h3002, 32'h1234_5678, 2, 0, 0, 32'd0);
        txn(1, 1, 32'h3000, 32'h1234_5678, 2, 0, 0, 32'd0);
        check("err_kept_rd", mem_read, 32'hFFFF_8001);

        // Reset in the second ACCESS cycle of a stalled lw.
        @(negedge clk);
        rd_en = 1'b1; wr_en = 1'b0; size = 2'd2; addr = 32'h40; bus_ready = 1'b0;
        @(posedge clk);
        #1 rd_en = 1'b0;
        @(negedge clk);
        check("rst_txn_req", 32'(bus_req), 32'd1);
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check("rst_drops_req", 32'(bus_req), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_clears_rd", mem_read, 32'd0);
        exp_rd = 32'd0;
        @(negedge clk);
        rst = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("post_rst_quiet", {29'd0, done, err, busy}, 32'd0);
        end

`ifdef DMEM_TIMEOUT_EN
        begin
            bit got;
            got = 0;
            txn(1, 0, 32'h50, 32'd0, 2, 0, 0, 32'hCAFE_F00D);
            @(negedge clk);
            rd_en = 1'b1; size = 2'd2; addr = 32'h60; bus_ready = 1'b0;
            @(posedge clk);
            #1 rd_en = 1'b0;
            for (int k = 1; k <= 40 && !got; k++) begin
                @(negedge clk);
                if (err) begin
                    got = 1;
                    check("timeout_cycle", 32'(k), 32'd18);
                    check("timeout_req_low", 32'(bus_req), 32'd0);
                    check("timeout_no_done", 32'(done), 32'd0);
                    check("timeout_rd_kept", mem_read, exp_rd);
                end
            end
            if (!got) check("timeout_seen", 32'd0, 32'd1);
            @(negedge clk);
            check("timeout_busy_clear", 32'(busy), 32'd0);
        end
`endif

        // Randomized traffic, including illegal sizes/alignments and both-enable requests.
        for (int i = 0; i < 150; i++) begin
            int op;
            op = $urandom_range(0, 9);
            txn((op < 5) || (op == 9), (op >= 5), $urandom, $urandom, $urandom_range(0, 3),
                1'($urandom), $urandom_range(0, 3), $urandom);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/data_mem_interface.md
Name: data_mem_interface

Overview:
- Load/store stage directly downstream of control_unit.
- Takes the unit's memory request (addr, rd_en, wr_en, store data) plus access size, and runs a word-aligned request/ready handshake to data memory.
- Places store bytes on the correct lanes with byte enables.
- Returns load data already lane-extracted and sign/zero-extended on mem_read, so control_unit forwards it to the register file unchanged.

Parameters:
- ADDR_W, 32, address width; bus_addr is word-aligned.
- TIMEOUT_CYCLES, 16, bus wait limit; used only with the optional feature.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- rd_en  input  1  load request from control_unit.
- wr_en  input  1  store request from control_unit.
- addr  input  ADDR_W  byte address from control_unit.
- mem_write  input  32  store data; LSB-justified for sb/sh.
- size  input  2  access size: 00 byte, 01 half, 10 word, 11 illegal.
- ld_unsigned  input  1  1 = zero-extend (lbu/lhu), 0 = sign-extend.
- mem_read  output  32  extended load data to control_unit.
- done  output  1  one-cycle completion pulse.
- err  output  1  one-cycle error pulse.
- busy  output  1  high from request capture until done/err.
- bus_req  output  1  memory request, held until bus_ready.
- bus_we  output  1  1 = write.
- bus_addr  output  ADDR_W  {addr[ADDR_W-1:2], 2'b00}.
- bus_be  output  4  byte-lane enables.
- bus_wdata  output  32  lane-replicated store data.
- bus_ready  input  1  memory accept/complete.
- bus_rdata  input  32  raw word from memory.

Behaviour:
- Reset (rst=0, asynchronous): all outputs 0; FSM to IDLE. Reset mid-transaction drops bus_req immediately, discards the access and produces no done/err.
- FSM states: IDLE, ACCESS, RESP.
- IDLE → capture: on a clock edge where rd_en|wr_en=1, the block registers addr, mem_write, size, ld_unsigned and the direction, and raises busy.
  - If legal: go to ACCESS; bus_req=1 in the next cycle.
  - If illegal: go to RESP with err.
- Illegal requests (no bus access, err pulse one cycle after capture):
  - rd_en & wr_en both high.
  - size = 11.
  - half access with addr[0] = 1.
  - word access with addr[1:0] ≠ 00.
- ACCESS: bus_req, bus_we, bus_addr, bus_be and bus_wdata are registered and stable until bus_ready is sampled high. On that edge:
  - loads register the extracted data;
  - bus_req drops;
  - FSM goes to RESP.
- bus_ready already high in the first ACCESS cycle gives zero wait states.
- RESP: done=1 (or err=1) for exactly one cycle; busy=0 from the next cycle; return to IDLE.
- Requests arriving while busy are ignored, never queued.
- Latency: capture edge N → bus_req high in cycle N+1 → with zero wait states, done high in cycle N+2. Each wait cycle adds 1.
- Byte enables:
  - byte: bus_be = 4'b0001 << addr[1:0].
  - half: 0011 for addr[1]=0, 1100 for addr[1]=1.
  - word: 1111.
- Store data: byte replicated ×4; half replicated ×2; word as-is.
- Load extraction: byte = bus_rdata[8*addr[1:0] +: 8]; half = bus_rdata[16*addr[1] +: 16]. Extend to 32 bits per ld_unsigned.
- mem_read holds its value until the next completed load; stores and errors leave it unchanged.
- bus_we = 0, bus_be = 0 and bus_wdata = 0 whenever bus_req = 0.

Optional Feature:
- Macro: DMEM_TIMEOUT_EN.
- Defined: a wait counter clears on entry to ACCESS and increments each cycle bus_ready = 0. When it reaches TIMEOUT_CYCLES:
  - bus_req drops;
  - FSM goes to RESP with err = 1;
  - mem_read is unchanged.
- Undefined: no counter; ACCESS waits indefinitely for bus_ready.

Test Plan:
- sb with addr=0x1003, mem_write=0x000000A5, bus_ready tied high → bus_addr=0x1000, bus_be=1000, bus_wdata=0xA5A5A5A5; done in cycle N+2.
- lb with addr=0x2001, ld_unsigned=0, bus_rdata=0x1234_80FF → mem_read=0xFFFFFF80. Repeat with ld_unsigned=1 → mem_read=0x00000080.
- lh with addr=0x2002, bus_rdata=0x8001_0000, ld_unsigned=0, bus_ready delayed 3 cycles → bus_req high for 4 cycles, mem_read=0xFFFF8001, done at N+5.
- sw with addr=0x3002 → err pulse at N+1, bus_req never asserted, done=0. rd_en=wr_en=1 → err likewise.
- lw started, bus_ready held low, rst pulsed low in cycle 2 of ACCESS → bus_req=0 immediately; no done/err; busy=0.
- With DMEM_TIMEOUT_EN and TIMEOUT_CYCLES=16, bus_ready held low → err at cycle N+18 (16 wait cycles after bus_req rises), bus_req low, mem_read unchanged.
